// File: rtl/pipe_ctrl_regs.sv
// ID->EXE->MEM->WB control-field and valid-flag pipeline for the 5-stage MIPS core,
// with hazard feedback to the pipeline controller and saturating retire/stall counters.
module pipe_ctrl_regs #(
  parameter int          CNT_W    = 32,
  parameter logic [4:0]  LINK_REG = 5'd31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_rst,
  input  logic             if_en,
  input  logic             id_rst,
  input  logic             id_en,
  input  logic             exe_rst,
  input  logic             exe_en,
  input  logic             mem_rst,
  input  logic             mem_en,
  input  logic             wb_rst,
  input  logic             wb_en,
  input  logic [31:0]      inst_id,
  input  logic             mem_ren,
  input  logic             mem_wen,
  input  logic [1:0]       wb_addr_src,
  input  logic             wb_data_src,
  input  logic             wb_wen,
  output logic             if_valid,
  output logic             id_valid,
  output logic             exe_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [4:0]       regw_addr_exe,
  output logic [4:0]       regw_addr_mem,
  output logic [4:0]       regw_addr_wb,
  output logic             wb_wen_exe,
  output logic             wb_wen_mem,
  output logic             wb_wen_wb,
  output logic             is_load_exe,
  output logic             mem_ren_mem,
  output logic             mem_wen_mem,
  output logic             wb_data_src_wb,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             if_valid_q, if_valid_d;
  logic             id_valid_q, id_valid_d;
  logic             exe_valid_q, exe_valid_d;
  logic [4:0]       exe_addr_q, exe_addr_d;
  logic             exe_mem_ren_q, exe_mem_ren_d;
  logic             exe_mem_wen_q, exe_mem_wen_d;
  logic             exe_wb_wen_q, exe_wb_wen_d;
  logic             exe_wb_src_q, exe_wb_src_d;
  logic             mem_valid_q, mem_valid_d;
  logic [4:0]       mem_addr_q, mem_addr_d;
  logic             mem_mem_ren_q, mem_mem_ren_d;
  logic             mem_mem_wen_q, mem_mem_wen_d;
  logic             mem_wb_wen_q, mem_wb_wen_d;
  logic             mem_wb_src_q, mem_wb_src_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic             wb_wb_wen_q, wb_wb_wen_d;
  logic             wb_wb_src_q, wb_wb_src_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [4:0]       id_addr;
  logic             unused_inst_bits;

  assign unused_inst_bits = ^{inst_id[31:21], inst_id[10:0]};

  always_comb begin
    case (wb_addr_src)
      2'd1:    id_addr = inst_id[20:16];
      2'd2:    id_addr = LINK_REG;
      default: id_addr = inst_id[15:11];
    endcase
  end

  always_comb begin
    if_valid_d    = if_valid_q;
    id_valid_d    = id_valid_q;
    exe_valid_d   = exe_valid_q;
    exe_addr_d    = exe_addr_q;
    exe_mem_ren_d = exe_mem_ren_q;
    exe_mem_wen_d = exe_mem_wen_q;
    exe_wb_wen_d  = exe_wb_wen_q;
    exe_wb_src_d  = exe_wb_src_q;
    mem_valid_d   = mem_valid_q;
    mem_addr_d    = mem_addr_q;
    mem_mem_ren_d = mem_mem_ren_q;
    mem_mem_wen_d = mem_mem_wen_q;
    mem_wb_wen_d  = mem_wb_wen_q;
    mem_wb_src_d  = mem_wb_src_q;
    wb_valid_d    = wb_valid_q;
    wb_addr_d     = wb_addr_q;
    wb_wb_wen_d   = wb_wb_wen_q;
    wb_wb_src_d   = wb_wb_src_q;
    retired_d     = retired_q;
    stall_d       = stall_q;

    if (if_rst)     if_valid_d = 1'b0;
    else if (if_en) if_valid_d = 1'b1;

    if (id_rst)     id_valid_d = 1'b0;
    else if (id_en) id_valid_d = if_valid_q;

    // Loading from an invalid upstream stage yields an all-zero bubble.
    if (exe_rst) begin
      exe_valid_d   = 1'b0;
      exe_addr_d    = '0;
      exe_mem_ren_d = 1'b0;
      exe_mem_wen_d = 1'b0;
      exe_wb_wen_d  = 1'b0;
      exe_wb_src_d  = 1'b0;
    end else if (exe_en) begin
      exe_valid_d   = id_valid_q;
      exe_addr_d    = id_valid_q ? id_addr : 5'd0;
      exe_mem_ren_d = id_valid_q & mem_ren;
      exe_mem_wen_d = id_valid_q & mem_wen;
      exe_wb_wen_d  = id_valid_q & wb_wen;
      exe_wb_src_d  = id_valid_q & wb_data_src;
    end

    if (mem_rst) begin
      mem_valid_d   = 1'b0;
      mem_addr_d    = '0;
      mem_mem_ren_d = 1'b0;
      mem_mem_wen_d = 1'b0;
      mem_wb_wen_d  = 1'b0;
      mem_wb_src_d  = 1'b0;
    end else if (mem_en) begin
      mem_valid_d   = exe_valid_q;
      mem_addr_d    = exe_valid_q ? exe_addr_q : 5'd0;
      mem_mem_ren_d = exe_valid_q & exe_mem_ren_q;
      mem_mem_wen_d = exe_valid_q & exe_mem_wen_q;
      mem_wb_wen_d  = exe_valid_q & exe_wb_wen_q;
      mem_wb_src_d  = exe_valid_q & exe_wb_src_q;
    end

    if (wb_rst) begin
      wb_valid_d  = 1'b0;
      wb_addr_d   = '0;
      wb_wb_wen_d = 1'b0;
      wb_wb_src_d = 1'b0;
    end else if (wb_en) begin
      wb_valid_d  = mem_valid_q;
      wb_addr_d   = mem_valid_q ? mem_addr_q : 5'd0;
      wb_wb_wen_d = mem_valid_q & mem_wb_wen_q;
      wb_wb_src_d = mem_valid_q & mem_wb_src_q;
    end

    // Counters stick at all-ones rather than wrapping.
    if (wb_valid_q && wb_en && !wb_rst && (retired_q != {CNT_W{1'b1}}))
      retired_d = retired_q + 1'b1;
    if (!id_en && exe_rst && id_valid_q && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q    <= 1'b0;
      id_valid_q    <= 1'b0;
      exe_valid_q   <= 1'b0;
      exe_addr_q    <= '0;
      exe_mem_ren_q <= 1'b0;
      exe_mem_wen_q <= 1'b0;
      exe_wb_wen_q  <= 1'b0;
      exe_wb_src_q  <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_mem_ren_q <= 1'b0;
      mem_mem_wen_q <= 1'b0;
      mem_wb_wen_q  <= 1'b0;
      mem_wb_src_q  <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_wb_wen_q   <= 1'b0;
      wb_wb_src_q   <= 1'b0;
      retired_q     <= '0;
      stall_q       <= '0;
    end else begin
      if_valid_q    <= if_valid_d;
      id_valid_q    <= id_valid_d;
      exe_valid_q   <= exe_valid_d;
      exe_addr_q    <= exe_addr_d;
      exe_mem_ren_q <= exe_mem_ren_d;
      exe_mem_wen_q <= exe_mem_wen_d;
      exe_wb_wen_q  <= exe_wb_wen_d;
      exe_wb_src_q  <= exe_wb_src_d;
      mem_valid_q   <= mem_valid_d;
      mem_addr_q    <= mem_addr_d;
      mem_mem_ren_q <= mem_mem_ren_d;
      mem_mem_wen_q <= mem_mem_wen_d;
      mem_wb_wen_q  <= mem_wb_wen_d;
      mem_wb_src_q  <= mem_wb_src_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_wb_wen_q   <= wb_wb_wen_d;
      wb_wb_src_q   <= wb_wb_src_d;
      retired_q     <= retired_d;
      stall_q       <= stall_d;
    end
  end

  assign if_valid       = if_valid_q;
  assign id_valid       = id_valid_q;
  assign exe_valid      = exe_valid_q;
  assign mem_valid      = mem_valid_q;
  assign wb_valid       = wb_valid_q;
  assign regw_addr_exe  = exe_addr_q;
  assign regw_addr_mem  = mem_addr_q;
  assign regw_addr_wb   = wb_addr_q;
  assign wb_wen_exe     = exe_valid_q & exe_wb_wen_q;
  assign wb_wen_mem     = mem_valid_q & mem_wb_wen_q;
  assign wb_wen_wb      = wb_valid_q & wb_wb_wen_q;
  assign is_load_exe    = exe_valid_q & exe_mem_ren_q;
  assign mem_ren_mem    = mem_valid_q & mem_mem_ren_q;
  assign mem_wen_mem    = mem_valid_q & mem_mem_wen_q;
  assign wb_data_src_wb = wb_wb_src_q;
  assign retired_cnt    = retired_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Bench for pipe_ctrl_regs: directed pipeline scenarios then random traffic, checked against
// a slot-level reference model; a second CNT_W=4 instance exercises counter saturation.
module tb_pipe_ctrl_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_rst, if_en, id_rst, id_en, exe_rst, exe_en;
  logic        mem_rst, mem_en, wb_rst, wb_en;
  logic [31:0] inst_id;
  logic        mem_ren, mem_wen, wb_data_src, wb_wen;
  logic [1:0]  wb_addr_src;

  logic        if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic [4:0]  regw_addr_exe, regw_addr_mem, regw_addr_wb;
  logic        wb_wen_exe, wb_wen_mem, wb_wen_wb, is_load_exe, mem_ren_mem, mem_wen_mem;
  logic        wb_data_src_wb;
  logic [31:0] retired_cnt, stall_cnt;

  logic        s_if_valid, s_id_valid, s_exe_valid, s_mem_valid, s_wb_valid;
  logic [4:0]  s_regw_addr_exe, s_regw_addr_mem, s_regw_addr_wb;
  logic        s_wb_wen_exe, s_wb_wen_mem, s_wb_wen_wb, s_is_load_exe, s_mem_ren_mem;
  logic        s_mem_wen_mem, s_wb_data_src_wb;
  logic [3:0]  s_retired_cnt, s_stall_cnt;

  pipe_ctrl_regs dut (
    .clk(clk), .rst(rst), .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
    .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
    .wb_rst(wb_rst), .wb_en(wb_en), .inst_id(inst_id), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .wb_addr_src(wb_addr_src), .wb_data_src(wb_data_src), .wb_wen(wb_wen),
    .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid), .mem_valid(mem_valid),
    .wb_valid(wb_valid), .regw_addr_exe(regw_addr_exe), .regw_addr_mem(regw_addr_mem),
    .regw_addr_wb(regw_addr_wb), .wb_wen_exe(wb_wen_exe), .wb_wen_mem(wb_wen_mem),
    .wb_wen_wb(wb_wen_wb), .is_load_exe(is_load_exe), .mem_ren_mem(mem_ren_mem),
    .mem_wen_mem(mem_wen_mem), .wb_data_src_wb(wb_data_src_wb),
    .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  pipe_ctrl_regs #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .if_rst(if_rst), .if_en(if_en), .id_rst(id_rst), .id_en(id_en),
    .exe_rst(exe_rst), .exe_en(exe_en), .mem_rst(mem_rst), .mem_en(mem_en),
    .wb_rst(wb_rst), .wb_en(wb_en), .inst_id(inst_id), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .wb_addr_src(wb_addr_src), .wb_data_src(wb_data_src), .wb_wen(wb_wen),
    .if_valid(s_if_valid), .id_valid(s_id_valid), .exe_valid(s_exe_valid),
    .mem_valid(s_mem_valid), .wb_valid(s_wb_valid), .regw_addr_exe(s_regw_addr_exe),
    .regw_addr_mem(s_regw_addr_mem), .regw_addr_wb(s_regw_addr_wb),
    .wb_wen_exe(s_wb_wen_exe), .wb_wen_mem(s_wb_wen_mem), .wb_wen_wb(s_wb_wen_wb),
    .is_load_exe(s_is_load_exe), .mem_ren_mem(s_mem_ren_mem), .mem_wen_mem(s_mem_wen_mem),
    .wb_data_src_wb(s_wb_data_src_wb), .retired_cnt(s_retired_cnt), .stall_cnt(s_stall_cnt)
  );

  // One pipeline slot as the model sees it: an instruction or an all-zero bubble.
  typedef struct packed {
    logic       v;
    logic [4:0] a;
    logic       mr;
    logic       mw;
    logic       ww;
    logic       ds;
  } slot_t;

  slot_t  m_exe, m_mem, m_wb;
  logic   m_if, m_id;
  longint m_ret, m_stall;
  int     checks = 0;
  int     errors = 0;

  function automatic logic [4:0] resolve(input logic [31:0] inst, input logic [1:0] src);
    if (src == 2'd1) return inst[20:16];
    if (src == 2'd2) return 5'd31;
    return inst[15:11];
  endfunction

  function automatic longint sat(input longint x, input longint lim);
    return (x > lim) ? lim : x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("if_valid", 32'(if_valid), 32'(m_if));
    check("id_valid", 32'(id_valid), 32'(m_id));
    check("exe_valid", 32'(exe_valid), 32'(m_exe.v));
    check("mem_valid", 32'(mem_valid), 32'(m_mem.v));
    check("wb_valid", 32'(wb_valid), 32'(m_wb.v));
    check("regw_addr_exe", 32'(regw_addr_exe), 32'(m_exe.a));
    check("regw_addr_mem", 32'(regw_addr_mem), 32'(m_mem.a));
    check("regw_addr_wb", 32'(regw_addr_wb), 32'(m_wb.a));
    check("wb_wen_exe", 32'(wb_wen_exe), 32'(m_exe.ww));
    check("wb_wen_mem", 32'(wb_wen_mem), 32'(m_mem.ww));
    check("wb_wen_wb", 32'(wb_wen_wb), 32'(m_wb.ww));
    check("is_load_exe", 32'(is_load_exe), 32'(m_exe.mr));
    check("mem_ren_mem", 32'(mem_ren_mem), 32'(m_mem.mr));
    check("mem_wen_mem", 32'(mem_wen_mem), 32'(m_mem.mw));
    check("wb_data_src_wb", 32'(wb_data_src_wb), 32'(m_wb.ds));
    check("retired_cnt", retired_cnt, 32'(sat(m_ret, 64'hFFFF_FFFF)));
    check("stall_cnt", stall_cnt, 32'(sat(m_stall, 64'hFFFF_FFFF)));
    check("small_retired", 32'(s_retired_cnt), 32'(sat(m_ret, 15)));
    check("small_stall", 32'(s_stall_cnt), 32'(sat(m_stall, 15)));
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic step();
    slot_t  n_exe, n_mem, n_wb, id_slot;
    logic   n_if, n_id;
    longint n_ret, n_stall;
    id_slot = '{v: 1'b1, a: resolve(inst_id, wb_addr_src), mr: mem_ren, mw: mem_wen,
                ww: wb_wen, ds: wb_data_src};
    if (rst) begin
      n_if = 0; n_id = 0; n_exe = '0; n_mem = '0; n_wb = '0; n_ret = 0; n_stall = 0;
    end else begin
      n_ret   = m_ret + ((m_wb.v && wb_en && !wb_rst) ? 1 : 0);
      n_stall = m_stall + ((!id_en && exe_rst && m_id) ? 1 : 0);
      n_if  = if_rst ? 1'b0 : (if_en ? 1'b1 : m_if);
      n_id  = id_rst ? 1'b0 : (id_en ? m_if : m_id);
      n_exe = exe_rst ? '0 : (exe_en ? (m_id ? id_slot : '0) : m_exe);
      n_mem = mem_rst ? '0 : (mem_en ? (m_exe.v ? m_exe : '0) : m_mem);
      n_wb  = wb_rst ? '0 : (wb_en ? (m_mem.v ? m_mem : '0) : m_wb);
    end
    @(posedge clk);
    #1;
    m_if = n_if; m_id = n_id; m_exe = n_exe; m_mem = n_mem; m_wb = n_wb;
    m_ret = n_ret; m_stall = n_stall;
    check_all();
  endtask

  task automatic set_en(input logic v);
    if_en = v; id_en = v; exe_en = v; mem_en = v; wb_en = v;
    if_rst = 0; id_rst = 0; exe_rst = 0; mem_rst = 0; wb_rst = 0;
  endtask

  task automatic set_ctrl(input logic [31:0] inst, input logic mr, input logic mw,
                          input logic [1:0] src, input logic ds, input logic ww);
    inst_id = inst; mem_ren = mr; mem_wen = mw; wb_addr_src = src; wb_data_src = ds;
    wb_wen = ww;
  endtask

  localparam logic [31:0] LW_5_1  = {6'h23, 5'd1, 5'd5, 16'h0000};
  localparam logic [31:0] JAL_RT7 = {6'h03, 5'd0, 5'd7, 16'h0040};

  initial begin
    m_if = 0; m_id = 0; m_exe = '0; m_mem = '0; m_wb = '0; m_ret = 0; m_stall = 0;
    set_en(1'b1);
    set_ctrl(LW_5_1, 1, 0, 2'd1, 1, 1);

    rst = 1;
    step();
    check("reset_if_valid", 32'(if_valid), 32'd0);
    check("reset_retired", retired_cnt, 32'd0);
    step();
    rst = 0;
    step();
    check("release_if_valid", 32'(if_valid), 32'd1);
    step();
    step();
    check("lw_is_load_exe", 32'(is_load_exe), 32'd1);
    check("lw_addr_exe", 32'(regw_addr_exe), 32'd5);
    set_ctrl(32'h0, 0, 0, 2'd0, 0, 0);
    step();
    check("lw_mem_ren_mem", 32'(mem_ren_mem), 32'd1);
    step();
    check("lw_wb_wen_wb", 32'(wb_wen_wb), 32'd1);
    check("lw_wb_data_src", 32'(wb_data_src_wb), 32'd1);
    check("lw_addr_wb", 32'(regw_addr_wb), 32'd5);

    set_ctrl(LW_5_1, 1, 0, 2'd1, 1, 1);
    if_en = 0; id_en = 0; exe_rst = 1;
    step();
    check("stall_exe_valid", 32'(exe_valid), 32'd0);
    check("stall_wb_wen_exe", 32'(wb_wen_exe), 32'd0);
    check("stall_cnt_one", stall_cnt, 32'd1);
    set_en(1'b1);
    step();
    check("stall_lw_late", 32'(is_load_exe), 32'd1);

    set_ctrl(JAL_RT7, 0, 0, 2'd2, 0, 1);
    step();
    check("jal_link_addr", 32'(regw_addr_exe), 32'd31);
    set_ctrl(32'h0, 0, 0, 2'd0, 0, 0);
    step();

    mem_rst = 1;
    step();
    check("mem_rst_wins", 32'(mem_valid), 32'd0);
    mem_rst = 0;

    set_en(1'b0);
    set_ctrl(32'h1234_5678, 1, 1, 2'd0, 1, 1);
    for (int i = 0; i < 5; i++) step();

    set_en(1'b1);
    for (int i = 0; i < 25; i++) begin
      set_ctrl($urandom, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b1);
      step();
    end
    check("small_retired_sat", 32'(s_retired_cnt), 32'd15);

    rst = 1;
    step();
    check("midrst_retired", retired_cnt, 32'd0);
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    rst = 0;

    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) < 3);
      if_rst  = ($urandom_range(0, 99) < 8);
      id_rst  = ($urandom_range(0, 99) < 8);
      exe_rst = ($urandom_range(0, 99) < 12);
      mem_rst = ($urandom_range(0, 99) < 8);
      wb_rst  = ($urandom_range(0, 99) < 8);
      if_en   = ($urandom_range(0, 99) < 80);
      id_en   = ($urandom_range(0, 99) < 75);
      exe_en  = ($urandom_range(0, 99) < 85);
      mem_en  = ($urandom_range(0, 99) < 85);
      wb_en   = ($urandom_range(0, 99) < 85);
      set_ctrl($urandom, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
               1'($urandom));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
